// File: rtl/seq_shifter.sv
// Iterative 8-bit shifter: captures operand on start, shifts one bit per clock,
// and pulses done for one cycle when out holds the final result.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_r;
  logic [SHW-1:0]   count_r;
  logic             dir_r;
  logic             arith_r;
  logic [WIDTH-1:0] shifted_s;

  // Single-step shift of the working register using only the latched controls.
  always_comb begin
    shifted_s = out;
    if (dir_r) begin
      shifted_s = {out[WIDTH-2:0], 1'b0};
    end else if (arith_r) begin
      shifted_s = {out[WIDTH-1], out[WIDTH-1:1]};
    end else begin
      shifted_s = {1'b0, out[WIDTH-1:1]};
    end
  end

  // Control FSM with registered out/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count_r <= '0;
      dir_r   <= 1'b0;
      arith_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            out     <= inp;
            count_r <= shamt;
            dir_r   <= dir;
            arith_r <= arith;
            busy    <= 1'b1;
            if (shamt != '0) begin
              state_r <= SHIFT;
              done    <= 1'b0;
            end else begin
              state_r <= FIN;
              done    <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        SHIFT: begin
          out     <= shifted_s;
          count_r <= count_r - SHW'(1);
          busy    <= 1'b1;
          // Final shift edge: result is in out during the following cycle.
          if (count_r == SHW'(1)) begin
            state_r <= FIN;
            done    <= 1'b1;
          end else begin
            done    <= 1'b0;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: driver pushes expected results to a scoreboard,
// a negedge monitor pops and checks them whenever done is seen.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] inp;
  logic [2:0] shamt;
  logic       dir;
  logic       arith;
  logic [7:0] out;
  logic       busy;
  logic       done;

  seq_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .inp(inp), .shamt(shamt),
    .dir(dir), .arith(arith), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    int         edge_k;
    int         amt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks result, latency, busy length and pulse width on every done.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_run = busy_run + 1;
    else busy_run = 0;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", {24'd0, out}, {24'd0, e.res});
        check("latency", cyc, e.edge_k + e.amt);
        check("busy_len", busy_run, e.amt + 1);
        check("done_pulse", {31'd0, prev_done}, 32'd0);
      end
    end
    prev_done = done;
  end

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [7:0] i, input logic [2:0] s, input logic d,
                        input logic a, input logic [7:0] res);
    exp_t e;
    bit   seen = 1'b0;
    @(negedge clk);
    start = 1'b1; inp = i; shamt = s; dir = d; arith = a;
    e.res = res; e.edge_k = cyc + 1; e.amt = int'(s);
    sb.push_back(e);
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b1; inp = 8'hFF; shamt = 3'd0; dir = 1'b0; arith = 1'b0;
    // rst and start together: start must be dropped.
    repeat (2) @(negedge clk);
    check("reset_out", {24'd0, out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    run_op(8'hA6, 3'd3, 1'b0, 1'b0, 8'h14);
    run_op(8'h01, 3'd6, 1'b1, 1'b0, 8'h40);
    run_op(8'hAB, 3'd2, 1'b1, 1'b0, 8'hAC);
    run_op(8'hA6, 3'd3, 1'b0, 1'b1, 8'hF4);
    run_op(8'hA6, 3'd3, 1'b1, 1'b1, 8'h30);
    run_op(8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A);

    // Result holds through idle cycles.
    repeat (3) @(negedge clk);
    check("hold_out", {24'd0, out}, 32'h5A);
    check("hold_busy", {31'd0, busy}, 32'd0);

    // Start during SHIFT is ignored; next op follows back-to-back.
    @(negedge clk);
    start = 1'b1; inp = 8'h81; shamt = 3'd7; dir = 1'b0; arith = 1'b0;
    begin
      exp_t e;
      e.res = 8'h01; e.edge_k = cyc + 1; e.amt = 7;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; inp = 8'hFF; shamt = 3'd1; dir = 1'b1; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("timeout_ignore", 32'd0, 32'd1);
    run_op(8'h3C, 3'd2, 1'b0, 1'b1, 8'h0F);

    // Reset mid-shift after two of five shifts.
    @(negedge clk);
    start = 1'b1; inp = 8'hF1; shamt = 3'd5; dir = 1'b1; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_out", {24'd0, out}, 32'hC4);
    check("partial_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", {24'd0, out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (8) @(negedge clk);
    check("midrst_no_done", {31'd0, done}, 32'd0);
    run_op(8'h0F, 3'd4, 1'b1, 1'b0, 8'hF0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
